// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// Instruction fetch stage: owns the PC, keeps at most one imem read in flight and
// queues returned words in order with their PC and a pre-decoded immediate format.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [2:0]  ExtOp,
  input  logic        instr_ready
);

  localparam int unsigned PW  = $clog2(QDEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d, cnt_next;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0]   q_mem [QDEPTH];
  logic [63:0]   head;
  logic          ack, push, pop, space;
  logic          unused_pc_lsbs;

  // Redirect targets are word aligned; the low bits are deliberately ignored.
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign imem_req    = (state_q == ST_WAIT) || (state_q == ST_DROP);
  assign imem_addr   = fetch_pc_q;
  assign ack         = imem_ack & imem_req;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = (state_q == ST_WAIT) & ack & ~redirect_valid;
  assign cnt_next    = count_q + CW'(push) - CW'(pop);
  assign space       = cnt_next < CW'(QDEPTH);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = cnt_next;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    if (redirect_valid) begin
      // An ack arriving with the redirect retires the old request, so the new PC can issue now.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      state_d    = (state_q != ST_IDLE && !ack) ? ST_DROP : ST_WAIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (space) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = space ? ST_WAIT : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (ack) state_d = space ? ST_WAIT : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: queue storage has no reset; entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= {fetch_pc_q, imem_rdata};
  end

  assign head     = q_mem[rd_ptr_q];
  assign instr    = instr_valid ? head[31:0]  : NOP;
  assign instr_pc = instr_valid ? head[63:32] : 32'h0;

  always_comb begin
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: ExtOp = 3'b000;
      7'b0110111, 7'b0010111:                         ExtOp = 3'b001;
      7'b0100011:                                     ExtOp = 3'b010;
      7'b1100011:                                     ExtOp = 3'b011;
      7'b1101111:                                     ExtOp = 3'b100;
      default:                                        ExtOp = 3'b111;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
// Bench for ifu_fetch: a latency-programmable instruction memory, directed stimulus,
// and a scoreboard whose monitor compares every word decode consumes.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic [2:0]  ext;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  ExtOp;
  logic        instr_ready;

  int   n_checks = 0;
  int   n_errors = 0;
  int   mem_lat  = 0;
  exp_t exp_q[$];

  ifu_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .ExtOp          (ExtOp),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] word, input logic [2:0] ext);
    exp_q.push_back('{pc: pc, word: word, ext: ext});
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h300: return 32'h0050_0093;
      32'h304: return 32'h0000_12b7;
      32'h308: return 32'h0011_2023;
      32'h30c: return 32'hfe00_08e3;
      32'h310: return 32'h0080_00ef;
      32'h314: return 32'h0020_8033;
      default: return a | 32'h13;
    endcase
  endfunction

  // Memory: latches the address when a request starts, acks mem_lat cycles later.
  initial begin
    int          wc;
    logic [31:0] lat_addr;
    wc         = 0;
    lat_addr   = '0;
    imem_ack   = 1'b0;
    imem_rdata = 32'hdead_beef;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (!rst_n || !imem_req) begin
        wc = 0;
      end else begin
        if (wc == 0) lat_addr = imem_addr;
        if (wc == mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(lat_addr);
          wc         = 0;
        end else begin
          wc++;
        end
      end
    end
  end

  // Monitor: every consumed head must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got pc 0x%08h instr 0x%08h, expected no instruction",
                   instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          check("head_pc",    instr_pc,    e.pc);
          check("head_instr", instr,       e.word);
          check("head_extop", 32'(ExtOp),  32'(e.ext));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    mem_lat = lat;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // Reset state and zero-wait streaming.
    #12;
    check("rst_req",   32'(imem_req),    32'h0);
    check("rst_addr",  imem_addr,        32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr,            32'h0000_0013);
    check("rst_pc",    instr_pc,         32'h0);
    check("rst_extop", 32'(ExtOp),       32'h0);
    expect_instr(32'h0, 32'h13, 3'b000);
    expect_instr(32'h4, 32'h17, 3'b001);
    expect_instr(32'h8, 32'h1b, 3'b111);
    instr_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("t1_req_e1",   32'(imem_req),    32'h1);
    check("t1_addr_e1",  imem_addr,        32'h0);
    check("t1_valid_e1", 32'(instr_valid), 32'h0);
    step();
    check("t1_addr_e2",  imem_addr,        32'h4);
    check("t1_valid_e2", 32'(instr_valid), 32'h1);
    step();
    check("t1_addr_e3",  imem_addr,        32'h8);
    step();
    check("t1_addr_e4",  imem_addr,        32'hc);
    step();
    check("t1_addr_e5",  imem_addr,        32'h10);

    // Back-pressure fills the queue, then draining re-arms the fetch.
    do_reset(0);
    expect_instr(32'h0, 32'h13, 3'b000);
    expect_instr(32'h4, 32'h17, 3'b001);
    step();
    step();
    step();
    check("t2_full_req",   32'(imem_req),    32'h0);
    check("t2_full_addr",  imem_addr,        32'h8);
    check("t2_full_valid", 32'(instr_valid), 32'h1);
    step();
    check("t2_hold_req",   32'(imem_req),    32'h0);
    check("t2_hold_addr",  imem_addr,        32'h8);
    instr_ready = 1'b1;
    step();
    check("t2_rearm_req",  32'(imem_req),    32'h1);
    check("t2_rearm_addr", imem_addr,        32'h8);
    step();

    // Redirect during a slow request: the late response is discarded.
    do_reset(3);
    instr_ready = 1'b1;
    expect_instr(32'h100, 32'h113, 3'b000);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check("t3_drop_req",  32'(imem_req),    32'h1);
    check("t3_drop_addr", imem_addr,        32'h100);
    check("t3_drop_valid", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_wait_valid", 32'(instr_valid), 32'h0);
      check("t3_wait_addr",  imem_addr,        32'h100);
    end
    step();
    check("t3_new_valid", 32'(instr_valid), 32'h1);
    step();

    // Redirect together with ack and pop flushes the queue.
    do_reset(0);
    instr_ready = 1'b1;
    expect_instr(32'h0,   32'h13,  3'b000);
    expect_instr(32'h4,   32'h17,  3'b001);
    expect_instr(32'h220, 32'h233, 3'b111);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0222;
    step();
    redirect_valid = 1'b0;
    check("t4_flush_valid", 32'(instr_valid), 32'h0);
    check("t4_flush_req",   32'(imem_req),    32'h1);
    check("t4_flush_addr",  imem_addr,        32'h220);
    step();
    check("t4_refill_valid", 32'(instr_valid), 32'h1);
    step();

    // Immediate-format decode across every instruction class.
    do_reset(0);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    expect_instr(32'h300, 32'h0050_0093, 3'b000);
    expect_instr(32'h304, 32'h0000_12b7, 3'b001);
    expect_instr(32'h308, 32'h0011_2023, 3'b010);
    expect_instr(32'h30c, 32'hfe00_08e3, 3'b011);
    expect_instr(32'h310, 32'h0080_00ef, 3'b100);
    expect_instr(32'h314, 32'h0020_8033, 3'b111);
    step();
    redirect_valid = 1'b0;
    check("t5_idle_redirect_addr", imem_addr, 32'h300);
    for (int i = 0; i < 7; i++) step();

    // Asynchronous reset between edges while a request is outstanding.
    do_reset(1);
    expect_instr(32'h0, 32'h13, 3'b000);
    step();
    step();
    step();
    check("t6_pre_valid", 32'(instr_valid), 32'h1);
    check("t6_pre_req",   32'(imem_req),    32'h1);
    check("t6_pre_addr",  imem_addr,        32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_req",   32'(imem_req),    32'h0);
    check("t6_async_addr",  imem_addr,        32'h0);
    check("t6_async_valid", 32'(instr_valid), 32'h0);
    check("t6_async_instr", instr,            32'h0000_0013);
    mem_lat = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    instr_ready = 1'b1;
    step();
    check("t6_restart_req",  32'(imem_req), 32'h1);
    check("t6_restart_addr", imem_addr,     32'h0);
    step();
    check("t6_restart_valid", 32'(instr_valid), 32'h1);
    step();
    instr_ready = 1'b0;
    step();

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
